// File: rtl/combo_input_decoder.sv
// ---------------------------------------------------------------------------
// combo_input_decoder
//
// Turns one player's debounced button pulses into fighter actions. LEFT and
// RIGHT become FORWARD and BACK according to the direction the fighter faces.
// The last two direction tokens are kept in a short timed history. Each
// PUNCH or KICK becomes either a basic attack or a special move, and the
// result goes to the fighter FSM over a valid/ack handshake.
//
// Parameters
//   GAP_W    width of the inter-token gap counter
//   GAP_MAX  max cycles between consecutive tokens of a sequence (>= 2)
//
// Ports
//   clk_i           system clock, rising edge
//   reset_i         synchronous active-high reset
//   btn_left_i      one-cycle debounced LEFT pulse
//   btn_right_i     one-cycle debounced RIGHT pulse
//   btn_down_i      one-cycle debounced DOWN pulse
//   btn_punch_i     one-cycle debounced PUNCH pulse
//   btn_kick_i      one-cycle debounced KICK pulse
//   facing_right_i  1 = fighter faces right (sampled with the direction pulse)
//   action_ack_i    fighter FSM consumed the pending action
//   action_valid_o  an action is pending
//   action_code_o   1 PUNCH, 2 KICK, 4 FIREBALL, 5 UPPERCUT, 6 SWEEP, 0 idle
//   drop_cnt_o      saturating count of attacks lost while an action pended
//
// States
//   ST_IDLE    | no action pending; an accepted attack is resolved and latched
//   ST_PENDING | action held on the outputs until acknowledged
// ---------------------------------------------------------------------------
module combo_input_decoder #(
    parameter int               GAP_W   = 24,
    parameter logic [GAP_W-1:0] GAP_MAX = 24'd2_500_000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       btn_left_i,
    input  logic       btn_right_i,
    input  logic       btn_down_i,
    input  logic       btn_punch_i,
    input  logic       btn_kick_i,
    input  logic       facing_right_i,
    input  logic       action_ack_i,
    output logic       action_valid_o,
    output logic [2:0] action_code_o,
    output logic [7:0] drop_cnt_o
);

    typedef enum logic [1:0] {
        DIR_DOWN = 2'd0,
        DIR_FWD  = 2'd1,
        DIR_BACK = 2'd2
    } dir_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_PUNCH    = 3'd1;
    localparam logic [2:0] CODE_KICK     = 3'd2;
    localparam logic [2:0] CODE_FIREBALL = 3'd4;
    localparam logic [2:0] CODE_UPPERCUT = 3'd5;
    localparam logic [2:0] CODE_SWEEP    = 3'd6;

    localparam logic [GAP_W-1:0] AGE_ZERO = '0;
    localparam logic [GAP_W-1:0] AGE_ONE  = GAP_W'(1);
    localparam logic [7:0]       DROP_MAX = 8'hFF;

    // Registered state
    state_e           state_q,  state_d;
    logic             valid_q,  valid_d;
    logic [2:0]       code_q,   code_d;
    logic [7:0]       drop_q,   drop_d;
    dir_e             h0_q,     h0_d;
    dir_e             h1_q,     h1_d;
    logic             h0_v_q,   h0_v_d;
    logic             h1_v_q,   h1_v_d;
    logic [GAP_W-1:0] age_q,    age_d;

    // Token decode
    logic fwd_raw;
    logic back_raw;
    logic tok_p;
    logic tok_k;
    logic tok_down;
    logic tok_fwd;
    logic tok_back;
    logic tok_dir;
    logic tok_atk;
    dir_e dir_new;

    // History qualification and attack resolution
    logic       expired;
    logic       h0_live;
    logic       h1_live;
    logic       both_live;
    logic [2:0] atk_code;

    // Facing-relative mapping: the raw button that points toward the
    // opponent is FORWARD.
    always_comb begin
        fwd_raw  = facing_right_i ? btn_right_i : btn_left_i;
        back_raw = facing_right_i ? btn_left_i  : btn_right_i;
    end

    // One token per cycle, priority P > K > DOWN > FWD > BACK. Losers are
    // simply discarded.
    always_comb begin
        tok_p    = btn_punch_i;
        tok_k    = btn_kick_i & ~btn_punch_i;
        tok_down = btn_down_i & ~btn_punch_i & ~btn_kick_i;
        tok_fwd  = fwd_raw & ~btn_punch_i & ~btn_kick_i & ~btn_down_i;
        tok_back = back_raw & ~btn_punch_i & ~btn_kick_i & ~btn_down_i & ~fwd_raw;
        tok_dir  = tok_down | tok_fwd | tok_back;
        tok_atk  = tok_p | tok_k;
        if (tok_down) begin
            dir_new = DIR_DOWN;
        end else if (tok_fwd) begin
            dir_new = DIR_FWD;
        end else begin
            dir_new = DIR_BACK;
        end
    end

    // age == GAP_MAX means the newest entry is GAP_MAX+1 cycles old. That is
    // already outside the window, even if a token arrives in this very cycle
    // and so prevents the timeout clear.
    always_comb begin
        expired   = (age_q == GAP_MAX);
        h0_live   = h0_v_q & ~expired;
        h1_live   = h1_v_q & ~expired;
        both_live = h0_live & h1_live;
    end

    always_comb begin
        atk_code = CODE_NONE;
        if (tok_p) begin
            if (both_live && h0_q == DIR_DOWN && h1_q == DIR_FWD) begin
                atk_code = CODE_FIREBALL;
            end else if (both_live && h0_q == DIR_FWD && h1_q == DIR_DOWN) begin
                atk_code = CODE_UPPERCUT;
            end else begin
                atk_code = CODE_PUNCH;
            end
        end else if (tok_k) begin
            if (both_live && h0_q == DIR_DOWN && h1_q == DIR_BACK) begin
                atk_code = CODE_SWEEP;
            end else begin
                atk_code = CODE_KICK;
            end
        end
    end

    // Direction history and gap timer
    always_comb begin
        h0_d   = h0_q;
        h1_d   = h1_q;
        h0_v_d = h0_v_q;
        h1_v_d = h1_v_q;
        age_d  = age_q;

        if (tok_dir) begin
            // Shift. An expired H1 must not survive into H0.
            h0_d   = h1_q;
            h0_v_d = h1_live;
            h1_d   = dir_new;
            h1_v_d = 1'b1;
            age_d  = AGE_ZERO;
        end else if (tok_atk) begin
            age_d = AGE_ZERO;
            // A resolved attack consumes the history. A dropped attack leaves
            // it in place so a combo can be entered while the fighter is busy.
            if (state_q == ST_IDLE) begin
                h0_v_d = 1'b0;
                h1_v_d = 1'b0;
            end
        end else if (h0_v_q || h1_v_q) begin
            if (expired) begin
                h0_v_d = 1'b0;
                h1_v_d = 1'b0;
                age_d  = AGE_ZERO;
            end else begin
                age_d = age_q + AGE_ONE;
            end
        end
    end

    // Handshake FSM with registered outputs
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        code_d  = code_q;
        drop_d  = drop_q;

        case (state_q)
            ST_IDLE: begin
                if (tok_atk) begin
                    state_d = ST_PENDING;
                    valid_d = 1'b1;
                    code_d  = atk_code;
                end
            end
            ST_PENDING: begin
                // An attack in the same cycle as the ack is still a drop.
                // The slot frees only on the next edge.
                if (tok_atk && drop_q != DROP_MAX) begin
                    drop_d = drop_q + 8'd1;
                end
                if (action_ack_i) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    code_d  = CODE_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                code_d  = CODE_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            code_q  <= CODE_NONE;
            drop_q  <= 8'd0;
            h0_q    <= DIR_DOWN;
            h1_q    <= DIR_DOWN;
            h0_v_q  <= 1'b0;
            h1_v_q  <= 1'b0;
            age_q   <= AGE_ZERO;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            drop_q  <= drop_d;
            h0_q    <= h0_d;
            h1_q    <= h1_d;
            h0_v_q  <= h0_v_d;
            h1_v_q  <= h1_v_d;
            age_q   <= age_d;
        end
    end

    assign action_valid_o = valid_q;
    assign action_code_o  = code_q;
    assign drop_cnt_o     = drop_q;

endmodule

// File: tb/tb_combo_input_decoder.sv
// ---------------------------------------------------------------------------
// tb_combo_input_decoder
//
// Self-checking bench for combo_input_decoder with GAP_MAX = 8. Expected
// action codes are queued as each attack is driven. A monitor pops and
// compares them on every rising edge of action_valid_o. Drop counter, hold
// and reset behaviour are checked directly.
// ---------------------------------------------------------------------------
module tb_combo_input_decoder;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       btn_left_i;
    logic       btn_right_i;
    logic       btn_down_i;
    logic       btn_punch_i;
    logic       btn_kick_i;
    logic       facing_right_i;
    logic       action_ack_i;
    logic       action_valid_o;
    logic [2:0] action_code_o;
    logic [7:0] drop_cnt_o;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    logic prev_valid = 1'b0;

    combo_input_decoder #(
        .GAP_W   (24),
        .GAP_MAX (24'd8)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .btn_left_i     (btn_left_i),
        .btn_right_i    (btn_right_i),
        .btn_down_i     (btn_down_i),
        .btn_punch_i    (btn_punch_i),
        .btn_kick_i     (btn_kick_i),
        .facing_right_i (facing_right_i),
        .action_ack_i   (action_ack_i),
        .action_valid_o (action_valid_o),
        .action_code_o  (action_code_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reset_i) begin
            prev_valid = 1'b0;
        end else begin
            if (action_valid_o && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_code", 32'(action_code_o), 32'd0);
                end else begin
                    chk("sb_code", 32'(action_code_o), 32'(exp_q.pop_front()));
                end
            end
            prev_valid = action_valid_o;
        end
    end

    // One clock cycle with the given pulses; returns 1 time unit after the edge
    task automatic step(input logic l, input logic r, input logic d, input logic p, input logic k);
        btn_left_i  = l;
        btn_right_i = r;
        btn_down_i  = d;
        btn_punch_i = p;
        btn_kick_i  = k;
        @(posedge clk);
        #1;
        btn_left_i  = 1'b0;
        btn_right_i = 1'b0;
        btn_down_i  = 1'b0;
        btn_punch_i = 1'b0;
        btn_kick_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ack_cycle();
        action_ack_i = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        action_ack_i = 1'b0;
    endtask

    task automatic reset_cycle();
        reset_i = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_i = 1'b0;
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i        = 1'b1;
        btn_left_i     = 1'b0;
        btn_right_i    = 1'b0;
        btn_down_i     = 1'b0;
        btn_punch_i    = 1'b0;
        btn_kick_i     = 1'b0;
        facing_right_i = 1'b1;
        action_ack_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;

        chk("rst_valid", 32'(action_valid_o), 32'd0);
        chk("rst_code",  32'(action_code_o),  32'd0);
        chk("rst_drop",  32'(drop_cnt_o),     32'd0);

        // 1: fireball with long-held handshake
        facing_right_i = 1'b1;
        step(0, 0, 1, 0, 0);          // c0 DOWN
        idle(2);
        step(0, 1, 0, 0, 0);          // c3 RIGHT = FWD
        idle(2);
        exp_q.push_back(4);
        step(0, 0, 0, 1, 0);          // c6 PUNCH
        chk("t1_valid_c7", 32'(action_valid_o), 32'd1);
        idle(13);                     // through c19
        chk("t1_hold_valid", 32'(action_valid_o), 32'd1);
        chk("t1_hold_code",  32'(action_code_o),  32'd4);
        ack_cycle();                  // c20
        chk("t1_ack_valid", 32'(action_valid_o), 32'd0);
        chk("t1_ack_code",  32'(action_code_o),  32'd0);

        // 2: facing left mirrors LEFT/RIGHT
        facing_right_i = 1'b0;
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);          // RIGHT = BACK
        exp_q.push_back(6);
        step(0, 0, 0, 0, 1);
        ack_cycle();
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);          // LEFT = FWD
        exp_q.push_back(4);
        step(0, 0, 0, 1, 0);
        ack_cycle();

        // 3: window edges with GAP_MAX = 8
        facing_right_i = 1'b1;
        step(0, 0, 1, 0, 0);          // c0
        idle(7);
        step(0, 1, 0, 0, 0);          // c8
        idle(7);
        exp_q.push_back(4);
        step(0, 0, 0, 1, 0);          // c16
        ack_cycle();
        step(0, 0, 1, 0, 0);          // c0
        idle(7);
        step(0, 1, 0, 0, 0);          // c8
        idle(8);
        exp_q.push_back(1);
        step(0, 0, 0, 1, 0);          // c17, k = 9
        ack_cycle();
        step(0, 0, 1, 0, 0);          // c0
        idle(8);
        step(0, 1, 0, 0, 0);          // c9, link lost
        idle(3);
        exp_q.push_back(1);
        step(0, 0, 0, 1, 0);
        ack_cycle();

        // 4: simultaneous pulses
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        exp_q.push_back(4);
        step(0, 0, 0, 1, 1);          // PUNCH wins, KICK discarded
        chk("t4_pk_drop", 32'(drop_cnt_o), 32'd0);
        ack_cycle();
        step(0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);          // only FWD is stored
        exp_q.push_back(4);
        step(0, 0, 0, 1, 0);
        ack_cycle();

        // 5: drops while pending
        exp_q.push_back(1);
        step(0, 0, 0, 1, 0);
        chk("t5_valid", 32'(action_valid_o), 32'd1);
        repeat (10) step(0, 0, 0, 0, 1);
        chk("t5_drop10", 32'(drop_cnt_o), 32'd10);
        repeat (290) step(0, 0, 0, 0, 1);
        chk("t5_drop_sat",  32'(drop_cnt_o),     32'd255);
        chk("t5_code_hold", 32'(action_code_o),  32'd1);
        chk("t5_valid_hold", 32'(action_valid_o), 32'd1);
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("t5_dir_no_drop", 32'(drop_cnt_o), 32'd255);
        ack_cycle();
        exp_q.push_back(4);
        step(0, 0, 0, 1, 0);
        ack_cycle();

        // 6: reset mid-operation
        reset_cycle();
        chk("t6_pre_drop", 32'(drop_cnt_o), 32'd0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        exp_q.push_back(5);
        step(0, 0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0, 1);
        chk("t6_drop3", 32'(drop_cnt_o), 32'd3);
        step(0, 0, 1, 0, 0);          // live DOWN,FWD history before reset
        step(0, 1, 0, 0, 0);
        reset_cycle();
        chk("t6_rst_valid", 32'(action_valid_o), 32'd0);
        chk("t6_rst_code",  32'(action_code_o),  32'd0);
        chk("t6_rst_drop",  32'(drop_cnt_o),     32'd0);
        exp_q.push_back(1);
        step(0, 0, 0, 1, 0);
        chk("t6_p_valid", 32'(action_valid_o), 32'd1);
        action_ack_i = 1'b1;          // ack and kick together: kick dropped
        step(0, 0, 0, 0, 1);
        action_ack_i = 1'b0;
        chk("t6_ackdrop_valid", 32'(action_valid_o), 32'd0);
        chk("t6_ackdrop_cnt",   32'(drop_cnt_o),     32'd1);
        idle(3);
        chk("t6_no_rearm", 32'(action_valid_o), 32'd0);

        idle(2);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
